// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and helpers for the serial pattern generator
package seq_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int LEN_W     = $clog2(DEF_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP,
        DONE
    } state_t;

    function automatic int clamp_len(input int len, input int width);
        return (len > width) ? width : len;
    endfunction

endpackage

// File: rtl/pattern_shreg.sv
// rtl/pattern_shreg.sv - left-aligned loadable shift register with remaining-bit counter
module pattern_shreg #(
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LW-1:0]    load_len,
    output logic             msb,
    output logic             last
);

    logic [WIDTH-1:0] shreg;
    logic [LW-1:0]    bit_cnt;

    // load wins over shift so a repeat can restart on the cycle its last bit goes out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= load_data;
            bit_cnt <= load_len;
        end else if (shift) begin
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt - LW'(1);
        end
    end

    assign msb  = shreg[WIDTH-1];
    assign last = (bit_cnt == LW'(1));

endmodule

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial pattern transmitter with repeat count and inter-repeat gap
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CNT_W      = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_valid,
    output logic                       start_ready,
    input  logic [WIDTH-1:0]           pattern,
    input  logic [$clog2(WIDTH+1)-1:0] len,
    input  logic [CNT_W-1:0]           repeat_n,
    output logic                       sout,
    output logic                       sout_valid,
    output logic                       busy,
    output logic                       done
);

    localparam int LW = $clog2(WIDTH + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t           state, state_n;
    logic [WIDTH-1:0] pat_lat, pat_aligned, load_data;
    logic [LW-1:0]    len_lat, len_eff, load_len;
    logic [CNT_W-1:0] rep_cnt;
    logic [GW-1:0]    gap_cnt;
    logic             accept, sr_load, sr_shift, msb, last, gap_end;

    assign len_eff     = LW'(clamp_len(int'(len), WIDTH));
    assign pat_aligned = pattern << (WIDTH - int'(len_eff));
    assign accept      = (state == IDLE) && start_valid;
    assign gap_end     = (int'(gap_cnt) == GAP_CYCLES - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        load_data = pat_lat;
        load_len  = len_lat;
        case (state)
            IDLE: begin
                if (start_valid) begin
                    sr_load   = 1'b1;
                    load_data = pat_aligned;
                    load_len  = len_eff;
                    state_n   = (len_eff == '0 || repeat_n == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                sr_shift = 1'b1;
                if (last) begin
                    if (rep_cnt == CNT_W'(1)) begin
                        state_n = DONE;
                    end else if (GAP_CYCLES > 0) begin
                        state_n = GAP;
                    end else begin
                        sr_load = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_end) begin
                    sr_load = 1'b1;
                    state_n = SHIFT;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // latched job copy used to rebuild each repetition
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_lat <= '0;
            len_lat <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            if (accept) begin
                pat_lat <= pat_aligned;
                len_lat <= len_eff;
                rep_cnt <= repeat_n;
            end
            if (state == SHIFT && last) begin
                rep_cnt <= rep_cnt - CNT_W'(1);
                gap_cnt <= '0;
            end
            if (state == GAP) begin
                gap_cnt <= gap_cnt + GW'(1);
            end
        end
    end

    pattern_shreg #(
        .WIDTH (WIDTH),
        .LW    (LW)
    ) u_shreg (
        .clk       (clk),
        .rst       (rst),
        .load      (sr_load),
        .shift     (sr_shift),
        .load_data (load_data),
        .load_len  (load_len),
        .msb       (msb),
        .last      (last)
    );

    assign sout        = (state == SHIFT) && msb;
    assign sout_valid  = (state == SHIFT);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign start_ready = (state == IDLE);

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - randomized self-checking bench for seq_pattern_gen
module tb_seq_pattern_gen;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int GAP   = 2;

    logic             clk;
    logic             rst;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] pattern;
    logic [3:0]       len;
    logic [CNT_W-1:0] repeat_n;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    int checks;
    int failures;
    bit got_bits[$];

    seq_pattern_gen #(
        .WIDTH      (WIDTH),
        .CNT_W      (CNT_W),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .pattern     (pattern),
        .len         (len),
        .repeat_n    (repeat_n),
        .sout        (sout),
        .sout_valid  (sout_valid),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called #1 after an edge while the DUT is idle; leaves the bench #1 after an edge, DUT idle.
    task automatic run_job(input logic [7:0] p, input int l, input int r, input bit hold,
                           input string tag);
        int le;
        int n;
        bit ev, eb, ed;
        bit exp_v[$];
        bit exp_b[$];
        le = (l > WIDTH) ? WIDTH : l;
        if (le > 0) begin
            for (int rr = 0; rr < r; rr++) begin
                for (int i = 0; i < le; i++) begin
                    exp_v.push_back(1'b1);
                    exp_b.push_back(p[le-1-i]);
                end
                if (rr < r - 1) begin
                    for (int g = 0; g < GAP; g++) begin
                        exp_v.push_back(1'b0);
                        exp_b.push_back(1'b0);
                    end
                end
            end
        end
        n = exp_v.size();
        got_bits.delete();
        start_valid = 1'b1;
        pattern     = p;
        len         = l[3:0];
        repeat_n    = r[CNT_W-1:0];
        checks++;
        if (start_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s accept_ready got=%b exp=1", tag, start_ready);
        end
        @(posedge clk);
        #1;
        if (!hold) start_valid = 1'b0;
        for (int c = 1; c <= n + 1; c++) begin
            if (hold) begin
                pattern  = WIDTH'($urandom);
                len      = 4'($urandom);
                repeat_n = CNT_W'($urandom);
            end
            ev = (c <= n) ? exp_v[c-1] : 1'b0;
            eb = (c <= n) ? exp_b[c-1] : 1'b0;
            ed = (c == n + 1);
            checks++;
            if ({sout_valid, sout, done, busy, start_ready} !== {ev, eb, ed, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL %s cyc=%0d got{v,d,done,busy,rdy}=%b%b%b%b%b exp=%b%b%b10",
                         tag, c, sout_valid, sout, done, busy, start_ready, ev, eb, ed);
            end
            if (sout_valid === 1'b1) got_bits.push_back(sout);
            @(posedge clk);
            #1;
        end
        start_valid = 1'b0;
        checks++;
        if ({busy, start_ready, done, sout_valid} !== 4'b0100) begin
            failures++;
            $display("FAIL %s after_done got{busy,rdy,done,v}=%b%b%b%b exp=0100",
                     tag, busy, start_ready, done, sout_valid);
        end
    endtask

    function automatic int count_10110();
        int cnt;
        cnt = 0;
        for (int i = 0; i + 4 < got_bits.size(); i++) begin
            if (got_bits[i] && !got_bits[i+1] && got_bits[i+2] && got_bits[i+3] && !got_bits[i+4])
                cnt++;
        end
        return cnt;
    endfunction

    task automatic test_reset();
        rst         = 1'b0;
        start_valid = 1'b0;
        pattern     = '0;
        len         = '0;
        repeat_n    = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sout, sout_valid, busy, done, start_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_state got{sout,v,busy,done,rdy}=%b%b%b%b%b exp=00001",
                     sout, sout_valid, busy, done, start_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int det;
        run_job(8'b0001_0110, 5, 1, 1'b0, "single");
        det = count_10110();
        checks++;
        if (det != 1) begin
            failures++;
            $display("FAIL single_detect got=%0d exp=1", det);
        end
    endtask

    task automatic test_repeat_gap();
        int det;
        run_job(8'b0001_0110, 5, 2, 1'b0, "repeat_gap");
        det = count_10110();
        checks++;
        if (det != 2) begin
            failures++;
            $display("FAIL repeat_detect got=%0d exp=2", det);
        end
    endtask

    task automatic test_zero();
        run_job(8'hFF, 0, 3, 1'b0, "zero_len");
        run_job(8'hFF, 5, 0, 1'b0, "zero_rep");
    endtask

    task automatic test_clamp();
        run_job(8'hA5, 12, 1, 1'b0, "clamp");
    endtask

    task automatic test_back_to_back();
        run_job(8'b1100_1010, 8, 2, 1'b1, "hold_busy");
        run_job(8'b0000_0101, 3, 1, 1'b0, "second_job");
    endtask

    task automatic test_reset_midjob();
        start_valid = 1'b1;
        pattern     = 8'b0001_0110;
        len         = 4'd5;
        repeat_n    = 4'd1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if ({sout_valid, sout} !== 2'b11) begin
            failures++;
            $display("FAIL midjob_bit3 got{v,d}=%b%b exp=11", sout_valid, sout);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({sout, sout_valid, busy, done, start_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL midjob_reset got{sout,v,busy,done,rdy}=%b%b%b%b%b exp=00001",
                     sout, sout_valid, busy, done, start_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_job(8'b0001_0110, 5, 1, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            run_job(8'($urandom), int'($urandom_range(0, 12)), int'($urandom_range(0, 3)),
                    1'($urandom), "random");
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_repeat_gap();
        test_zero();
        test_clamp();
        test_back_to_back();
        test_reset_midjob();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
